// File: rtl/fifo_burst_reader_pkg.sv
// Shared state encoding and counter width for the FIFO burst reader.
package fifo_burst_reader_pkg;

  localparam int BURSTS_W = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    OPEN  = 2'd1,
    CLOSE = 2'd2
  } state_e;

endpackage

// File: rtl/fifo_burst_reader_skid_queue2.sv
// Two-entry in-order queue; accepts up to two pushes per cycle (push first, then push2).
module skid_queue2
  import fifo_burst_reader_pkg::*;
#(
  parameter int W = 17
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         push2_i,
  input  logic [W-1:0] push2_data_i,
  input  logic         pop_i,
  output logic [W-1:0] head_o,
  output logic         full_o,
  output logic         empty_o,
  output logic [1:0]   count_o
);

  logic [W-1:0] ent0_q, ent0_d, ent1_q, ent1_d;
  logic [1:0]   cnt_q, cnt_d, base_s;
  logic         pop_eff_s;

  assign pop_eff_s = pop_i && (cnt_q != 2'd0);
  assign base_s    = cnt_q - {1'b0, pop_eff_s};

  // Pop shifts the tail forward before new words are placed behind it.
  always_comb begin
    ent0_d = pop_eff_s ? ent1_q : ent0_q;
    ent1_d = ent1_q;
    cnt_d  = base_s;
    case ({push2_i, push_i})
      2'b01: begin
        if (base_s == 2'd0) begin
          ent0_d = push_data_i;
        end else begin
          ent1_d = push_data_i;
        end
        cnt_d = base_s + 2'd1;
      end
      2'b11: begin
        ent0_d = push_data_i;
        ent1_d = push2_data_i;
        cnt_d  = 2'd2;
      end
      default: begin
        cnt_d = base_s;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else if (clr_i) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      ent0_q <= ent0_d;
      ent1_q <= ent1_d;
      cnt_q  <= cnt_d;
    end
  end

  assign head_o  = ent0_q;
  assign full_o  = (cnt_q == 2'd2);
  assign empty_o = (cnt_q == 2'd0);
  assign count_o = cnt_q;

endmodule

// File: rtl/fifo_burst_reader.sv
// Pulls words from a FIFO and re-emits them as BURST-word bursts marked with out_last;
// a partial burst is closed after TIMEOUT cycles without new data.
module fifo_burst_reader
  import fifo_burst_reader_pkg::*;
#(
  parameter int WIDTH   = 16,
  parameter int BURST   = 4,
  parameter int TIMEOUT = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic                fifo_empty,
  input  logic                fifo_valid,
  input  logic [WIDTH-1:0]    fifo_rdata,
  output logic                pop,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_last,
  output logic [BURSTS_W-1:0] bursts_done,
  output logic                idle
);

  localparam int BIDX_W = $clog2(BURST);
  localparam int TMR_W  = $clog2(TIMEOUT + 1);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    pend_data_q, pend_data_d;
  logic                pend_v_q, pend_v_d;
  logic [BIDX_W-1:0]   beat_q, beat_d;
  logic [TMR_W-1:0]    timer_q, timer_d;
  logic [BURSTS_W-1:0] bursts_q;

  logic                push_s, push2_s;
  logic [WIDTH:0]      push_data_s, push2_data_s, head_s;
  logic                q_full_s, q_empty_s;
  logic [1:0]          q_cnt_s, occ_s;
  logic                deq_s, capture_s, final_s, space_s, timeout_s, commit_s;

  skid_queue2 #(.W(WIDTH + 1)) u_queue (
    .clk          (clk),
    .rst_n        (rst_n),
    .clr_i        (flush),
    .push_i       (push_s),
    .push_data_i  (push_data_s),
    .push2_i      (push2_s),
    .push2_data_i (push2_data_s),
    .pop_i        (deq_s),
    .head_o       (head_s),
    .full_o       (q_full_s),
    .empty_o      (q_empty_s),
    .count_o      (q_cnt_s)
  );

  assign occ_s     = q_cnt_s + {1'b0, pend_v_q};
  assign out_valid = !q_empty_s && !flush;
  assign deq_s     = out_valid && out_ready;
  assign pop       = rst_n && !fifo_empty && !flush &&
                     ((occ_s <= 2'd1) || ((occ_s == 2'd2) && deq_s));
  assign capture_s = pop && fifo_valid;
  assign final_s   = (beat_q == BIDX_W'(BURST - 1));
  assign space_s   = !q_full_s || deq_s;
  assign timeout_s = pend_v_q && (timer_q == TMR_W'(TIMEOUT)) && !capture_s;
  assign commit_s  = timeout_s && space_s;

  // Datapath next state: route captured/pending words into the queue and run the idle timer.
  always_comb begin
    push_s       = 1'b0;
    push2_s      = 1'b0;
    push_data_s  = {1'b0, pend_data_q};
    push2_data_s = {1'b1, fifo_rdata};
    pend_data_d  = pend_data_q;
    pend_v_d     = pend_v_q;
    beat_d       = beat_q;
    timer_d      = timer_q;
    if (capture_s) begin
      timer_d = '0;
      if (final_s) begin
        pend_v_d = 1'b0;
        beat_d   = '0;
        if (pend_v_q) begin
          push_s  = 1'b1;
          push2_s = 1'b1;
        end else begin
          push_s      = 1'b1;
          push_data_s = {1'b1, fifo_rdata};
        end
      end else begin
        push_s      = pend_v_q;
        pend_data_d = fifo_rdata;
        pend_v_d    = 1'b1;
        beat_d      = beat_q + BIDX_W'(1);
      end
    end else if (commit_s) begin
      push_s      = 1'b1;
      push_data_s = {1'b1, pend_data_q};
      pend_v_d    = 1'b0;
      beat_d      = '0;
      timer_d     = '0;
    end else if (pend_v_q) begin
      timer_d = (timer_q == TMR_W'(TIMEOUT)) ? timer_q : timer_q + TMR_W'(1);
    end else begin
      timer_d = '0;
    end
  end

  // Burst state machine.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (capture_s && !final_s) begin
          state_d = OPEN;
        end else begin
          state_d = IDLE;
        end
      end
      OPEN: begin
        if ((capture_s && final_s) || commit_s) begin
          state_d = IDLE;
        end else if (timeout_s) begin
          state_d = CLOSE;
        end else begin
          state_d = OPEN;
        end
      end
      CLOSE: begin
        if (commit_s) begin
          state_d = IDLE;
        end else begin
          state_d = CLOSE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      pend_data_q <= '0;
      pend_v_q    <= 1'b0;
      beat_q      <= '0;
      timer_q     <= '0;
    end else if (flush) begin
      state_q     <= IDLE;
      pend_data_q <= '0;
      pend_v_q    <= 1'b0;
      beat_q      <= '0;
      timer_q     <= '0;
    end else begin
      state_q     <= state_d;
      pend_data_q <= pend_data_d;
      pend_v_q    <= pend_v_d;
      beat_q      <= beat_d;
      timer_q     <= timer_d;
    end
  end

  // Completed-burst counter survives flush; only reset clears it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bursts_q <= '0;
    end else if (deq_s && head_s[WIDTH]) begin
      bursts_q <= bursts_q + BURSTS_W'(1);
    end else begin
      bursts_q <= bursts_q;
    end
  end

  assign out_data    = head_s[WIDTH-1:0];
  assign out_last    = head_s[WIDTH];
  assign bursts_done = bursts_q;
  assign idle        = q_empty_s && !pend_v_q && (beat_q == '0);

endmodule

// File: tb/tb_fifo_burst_reader.sv
// Directed bench for fifo_burst_reader (WIDTH=16, BURST=4, TIMEOUT=8) with a small FIFO model.
module tb_fifo_burst_reader;

  logic        clk = 1'b0;
  logic        rst_n, flush, out_ready, fv_block;
  logic        fifo_empty, fifo_valid, pop, out_valid, out_last, idle;
  logic [15:0] fifo_rdata, out_data, bursts_done;

  logic [15:0] mem [0:127];
  int          wr_ptr = 0;
  int          rd_ptr = 0;
  logic [16:0] log_q [$];
  int          cyc = 0, cap_cyc = 0, hs_cyc = 0;
  int          checks = 0, errors = 0;
  int          base, rd0, unstable;

  always #5 clk = ~clk;

  fifo_burst_reader #(.WIDTH(16), .BURST(4), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .fifo_empty  (fifo_empty),
    .fifo_valid  (fifo_valid),
    .fifo_rdata  (fifo_rdata),
    .pop         (pop),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_last    (out_last),
    .bursts_done (bursts_done),
    .idle        (idle)
  );

  assign fifo_empty = (rd_ptr == wr_ptr);
  assign fifo_rdata = mem[rd_ptr[6:0]];
  assign fifo_valid = pop && !fifo_empty && !fv_block;

  always @(posedge clk) begin
    if (pop && fifo_valid) rd_ptr <= rd_ptr + 1;
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (out_valid && out_ready) log_q.push_back({out_last, out_data});
    if (pop && fifo_valid && fifo_rdata == 16'h00A3) cap_cyc <= cyc;
    if (out_valid && out_ready && out_data == 16'h00A3) hs_cyc <= cyc;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic put(input logic [15:0] w);
    mem[wr_ptr[6:0]] = w;
    wr_ptr = wr_ptr + 1;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_log(input int n, input int budget, input string tag);
    int k;
    k = 0;
    while (log_q.size() < n && k < budget) begin
      @(posedge clk);
      #1;
      k++;
    end
    chk(tag, 32'(log_q.size() >= n), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1; fv_block = 1'b0;
    for (int i = 1; i <= 8; i++) put(16'(i));
    @(negedge clk);
    chk("rst_pop", 32'(pop), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_bursts", 32'(bursts_done), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    // Two full bursts back to back
    wait_log(8, 60, "t1_drain");
    for (int i = 0; i < 8; i++) begin
      chk("t1_word", 32'(log_q[i]), 32'({(i == 3 || i == 7), 16'(i + 1)}));
    end
    chk("t1_bursts", 32'(bursts_done), 32'd2);
    chk("t1_idle", 32'(idle), 32'd1);

    // Partial burst closed by timeout
    base = log_q.size();
    put(16'h00A1); put(16'h00A2); put(16'h00A3);
    wait_log(base + 3, 60, "t2_drain");
    chk("t2_a1", 32'(log_q[base]), 32'h000A1);
    chk("t2_a2", 32'(log_q[base + 1]), 32'h000A2);
    chk("t2_a3", 32'(log_q[base + 2]), 32'h100A3);
    chk("t2_latency", 32'(hs_cyc - cap_cyc), 32'd10);
    chk("t2_bursts", 32'(bursts_done), 32'd3);
    chk("t2_idle", 32'(idle), 32'd1);

    // Backpressure: out_ready low for 20 cycles with a full FIFO
    out_ready = 1'b0;
    base = log_q.size();
    rd0 = rd_ptr;
    unstable = 0;
    for (int i = 0; i < 8; i++) put(16'h00B0 + 16'(i));
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (out_valid && out_data !== 16'h00B0) unstable++;
    end
    chk("t3_popped_le3", 32'((rd_ptr - rd0) <= 3), 32'd1);
    chk("t3_hold", 32'(unstable), 32'd0);
    chk("t3_valid", 32'(out_valid), 32'd1);
    chk("t3_head", 32'(out_data), 32'h00B0);
    chk("t3_no_emit", 32'(log_q.size()), 32'(base));
    out_ready = 1'b1;
    wait_log(base + 8, 80, "t3_drain");
    for (int i = 0; i < 8; i++) begin
      chk("t3_word", 32'(log_q[base + i]), 32'({(i == 1 || i == 5 || i == 7), 16'h00B0 + 16'(i)}));
    end
    chk("t3_bursts", 32'(bursts_done), 32'd6);

    // Pop without fifo_valid is ignored
    fv_block = 1'b1;
    base = log_q.size();
    rd0 = rd_ptr;
    for (int i = 0; i < 4; i++) put(16'h00C0 + 16'(i));
    step(3);
    chk("t4_pop_req", 32'(pop), 32'd1);
    chk("t4_no_capture", 32'(rd_ptr), 32'(rd0));
    chk("t4_idle", 32'(idle), 32'd1);
    fv_block = 1'b0;
    wait_log(base + 4, 40, "t4_drain");
    for (int i = 0; i < 4; i++) begin
      chk("t4_word", 32'(log_q[base + i]), 32'({(i == 3), 16'h00C0 + 16'(i)}));
    end
    chk("t4_bursts", 32'(bursts_done), 32'd7);

    // Flush with two words held
    out_ready = 1'b0;
    base = log_q.size();
    put(16'h00D0); put(16'h00D1);
    step(3);
    chk("t5_held", 32'(idle), 32'd0);
    put(16'h00D2);
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("t5_flush_pop", 32'(pop), 32'd0);
    chk("t5_flush_valid", 32'(out_valid), 32'd0);
    step(1);
    flush = 1'b0;
    chk("t5_idle", 32'(idle), 32'd1);
    chk("t5_bursts", 32'(bursts_done), 32'd7);
    wait_log(base + 1, 40, "t5_drain");
    step(4);
    chk("t5_count", 32'(log_q.size()), 32'(base + 1));
    chk("t5_d2", 32'(log_q[base]), 32'h100D2);
    chk("t5_bursts_after", 32'(bursts_done), 32'd8);

    // Reset mid-burst
    out_ready = 1'b0;
    put(16'h00E0); put(16'h00E1); put(16'h00E2);
    step(3);
    rst_n = 1'b0;
    #1;
    chk("t6_pop", 32'(pop), 32'd0);
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_last", 32'(out_last), 32'd0);
    chk("t6_data", 32'(out_data), 32'd0);
    chk("t6_idle", 32'(idle), 32'd1);
    chk("t6_bursts", 32'(bursts_done), 32'd0);
    step(1);
    rst_n = 1'b1;
    out_ready = 1'b1;
    base = log_q.size();
    put(16'h00F1); put(16'h00F2); put(16'h00F3);
    wait_log(base + 4, 40, "t6_drain");
    chk("t6_w0", 32'(log_q[base]), 32'h000E2);
    chk("t6_w1", 32'(log_q[base + 1]), 32'h000F1);
    chk("t6_w2", 32'(log_q[base + 2]), 32'h000F2);
    chk("t6_w3", 32'(log_q[base + 3]), 32'h100F3);
    chk("t6_bursts_after", 32'(bursts_done), 32'd1);

    // Counter wrap from 0xFFFF
    force dut.bursts_q = 16'hFFFF;
    #1;
    release dut.bursts_q;
    step(1);
    chk("t7_preset", 32'(bursts_done), 32'h0000FFFF);
    base = log_q.size();
    for (int i = 0; i < 4; i++) put(16'h0070 + 16'(i));
    wait_log(base + 4, 40, "t7_drain");
    chk("t7_last", 32'(log_q[base + 3]), 32'h10073);
    chk("t7_wrap", 32'(bursts_done), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_burst_reader.md
FIFO_BURST_READER -- requirements
Module: fifo_burst_reader

Interface
REQ-001 Parameter WIDTH, default 16, data width in bits; SHALL match the attached FIFO's WIDTH.
REQ-002 Parameter BURST, default 4, words per full burst; SHALL be at least 2.
REQ-003 Parameter TIMEOUT, default 8, idle cycles before a partial burst is closed; SHALL be at least 1.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset; asynchronous, active-low.
REQ-006 flush  input  1  synchronous clear of all buffered state.
REQ-007 fifo_empty  input  1  FIFO empty flag.
REQ-008 fifo_valid  input  1  FIFO read-data valid, same cycle as pop.
REQ-009 fifo_rdata  input  WIDTH  FIFO read data, same cycle as pop.
REQ-010 pop  output  1  FIFO read request.
REQ-011 out_valid, out_ready  output, input  1 each  downstream handshake.
REQ-012 out_data  output  WIDTH  downstream data.
REQ-013 out_last  output  1  final word of a burst.
REQ-014 bursts_done  output  16  count of words emitted with out_last, wrapping.
REQ-015 idle  output  1  high when the queue, pending register and beat index are all empty or zero.

Function
REQ-016 Storage SHALL consist of a 2-entry output queue ({data, last}, FIFO order) plus one pending register; occ = queue_cnt + pending_v.
REQ-017 pop SHALL be high when !fifo_empty && !flush && (occ <= 1 || (occ == 2 && out_valid && out_ready)).
REQ-018 A word SHALL be captured only when pop && fifo_valid; pop without fifo_valid SHALL be ignored and beat_idx SHALL not advance.
REQ-019 Captured word with beat_idx == BURST-1 SHALL enter the queue with last=1; any pending word SHALL enter the queue ahead of it with last=0; beat_idx SHALL become 0.
REQ-020 Any other captured word SHALL go to the pending register; a previously pending word SHALL move to the queue with last=0; beat_idx SHALL increment.
REQ-021 out_valid SHALL equal queue_cnt != 0; out_data and out_last SHALL show the queue head; the head SHALL leave the queue on out_valid && out_ready.
REQ-022 out_data and out_last SHALL be held stable while out_valid && !out_ready.
REQ-023 Timer SHALL count cycles with pending_v && no capture, and SHALL reset to 0 on a capture or when pending is empty.
REQ-024 When the timer reaches TIMEOUT, the pending word SHALL enter the queue with last=1 and beat_idx SHALL become 0, provided queue_cnt < 2 or the head leaves in that cycle; otherwise the timer SHALL saturate until space exists.
REQ-025 State machine:
- IDLE (beat_idx==0, !pending_v)
- OPEN (burst in progress)
- CLOSE (timeout reached, awaiting queue space)
Transitions: IDLE->OPEN on a non-final capture; OPEN->IDLE on the final-beat capture or a timeout commit; OPEN->CLOSE on timeout without space; CLOSE->IDLE on commit.
REQ-026 bursts_done SHALL increment by 1 on each out_valid && out_ready && out_last, wrapping from 0xFFFF to 0.
REQ-027 flush SHALL, in the same cycle, force pop=0 and out_valid=0; at the next edge it SHALL clear the queue, pending register, beat_idx and timer and set the state to IDLE; bursts_done SHALL be unaffected.
REQ-028 Latency from a captured final beat to out_valid SHALL be 1 cycle when the queue is empty.

Reset
REQ-029 While rst_n=0: queue_cnt=0, pending_v=0, beat_idx=0, timer=0, state=IDLE, bursts_done=0.
REQ-030 While rst_n=0: outputs SHALL be pop=0, out_valid=0, out_last=0, out_data=0, idle=1.
REQ-031 Reset asserted mid-burst SHALL discard all held words; no partial burst SHALL be emitted afterwards.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, OPEN, CLOSE) and the bursts_done width constant (16).
REQ-033 The 2-entry output queue SHALL be a sub-module named skid_queue2 (push, pop, full, empty, count).

Verification
REQ-034 BURST=4, FIFO holds 8 words 0x0001..0x0008, out_ready=1 -> out_last exactly on 0x0004 and 0x0008; bursts_done=2; idle=1 at end.
REQ-035 FIFO supplies 0x00A1..0x00A3 then stays empty -> after TIMEOUT=8 idle cycles, 0x00A3 emitted with out_last=1; bursts_done=1.
REQ-036 out_ready=0 for 20 cycles with FIFO full -> at most 3 words popped, out_data stable, no drop; order preserved after out_ready=1.
REQ-037 flush mid-burst with 2 words held -> pop=0 and out_valid=0 that cycle; idle=1 next cycle; bursts_done unchanged.
REQ-038 rst_n low for 1 cycle mid-burst -> all outputs at reset values; the next burst starts with beat_idx=0.
REQ-039 Preset bursts_done to 0xFFFF and complete 1 burst -> bursts_done=0x0000.
